id_ex_stage: RTL and testbench

//   ID/EX pipeline register of the pipelined miniRV core. Captures the decoder control word, operands,

---
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register with load-use bubble insertion, flush,
//             global hold and saturating bubble/flush counters.
//  Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int         XLEN      = 32,
    parameter int         CNT_W     = 16,
    parameter logic [1:0] WSEL_LOAD = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             ex_flush_i,
    input  logic             id_have_inst,
    input  logic             id_read_rD1,
    input  logic             id_read_rD2,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_we,
    input  logic [1:0]       id_rf_wsel,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alub_sel,
    input  logic             id_ram_we,
    input  logic [2:0]       id_branch,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rD1,
    input  logic [XLEN-1:0]  id_rD2,
    input  logic [XLEN-1:0]  id_ext,
    output logic             ex_have_inst,
    output logic             ex_read_rD1,
    output logic             ex_read_rD2,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_rf_we,
    output logic [1:0]       ex_rf_wsel,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alub_sel,
    output logic             ex_ram_we,
    output logic [2:0]       ex_branch,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rD1,
    output logic [XLEN-1:0]  ex_rD2,
    output logic [XLEN-1:0]  ex_ext,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic             r_have_inst;
    logic             r_read_rD1;
    logic             r_read_rD2;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic             r_rf_we;
    logic [1:0]       r_rf_wsel;
    logic [3:0]       r_alu_op;
    logic             r_alub_sel;
    logic             r_ram_we;
    logic [2:0]       r_branch;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rD1;
    logic [XLEN-1:0]  r_rD2;
    logic [XLEN-1:0]  r_ext;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_ex_is_load;
    logic w_src_match;
    logic w_load_use;
    logic w_bubble;
    logic w_clear;
    logic w_load;

    // Hazard only when the EX load really writes a nonzero register that ID reads.
    assign w_ex_is_load = r_have_inst & r_rf_we & (r_rf_wsel == WSEL_LOAD) & (r_rd != 5'd0);
    assign w_src_match  = (id_read_rD1 & (id_rs1 == r_rd)) | (id_read_rD2 & (id_rs2 == r_rd));
    assign w_load_use   = w_ex_is_load & id_have_inst & w_src_match;
    assign stall_o      = w_load_use & ~ex_flush_i & ~hold_i;

    assign w_bubble = ex_flush_i | w_load_use;
    assign w_clear  = ~rst_n | (~hold_i & w_bubble);
    assign w_load   = rst_n & ~hold_i & ~w_bubble;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_have_inst <= 1'b0;
            r_read_rD1  <= 1'b0;
            r_read_rD2  <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rf_we     <= 1'b0;
            r_rf_wsel   <= '0;
            r_alu_op    <= '0;
            r_alub_sel  <= 1'b0;
            r_ram_we    <= 1'b0;
            r_branch    <= '0;
            r_pc        <= '0;
            r_rD1       <= '0;
            r_rD2       <= '0;
            r_ext       <= '0;
        end else if (w_load) begin
            r_have_inst <= id_have_inst;
            r_read_rD1  <= id_read_rD1;
            r_read_rD2  <= id_read_rD2;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_rf_we     <= id_rf_we;
            r_rf_wsel   <= id_rf_wsel;
            r_alu_op    <= id_alu_op;
            r_alub_sel  <= id_alub_sel;
            r_ram_we    <= id_ram_we;
            r_branch    <= id_branch;
            r_pc        <= id_pc;
            r_rD1       <= id_rD1;
            r_rD2       <= id_rD2;
            r_ext       <= id_ext;
        end
    end

    // A flush takes precedence, so a simultaneous load-use is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold_i) begin
            if (ex_flush_i) begin
                if (r_flush_cnt != c_CNT_MAX) begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                end
            end else if (w_load_use) begin
                if (r_stall_cnt != c_CNT_MAX) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end
        end
    end

    assign ex_have_inst = r_have_inst;
    assign ex_read_rD1  = r_read_rD1;
    assign ex_read_rD2  = r_read_rD2;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_rd        = r_rd;
    assign ex_rf_we     = r_rf_we;
    assign ex_rf_wsel   = r_rf_wsel;
    assign ex_alu_op    = r_alu_op;
    assign ex_alub_sel  = r_alub_sel;
    assign ex_ram_we    = r_ram_we;
    assign ex_branch    = r_branch;
    assign ex_pc        = r_pc;
    assign ex_rD1       = r_rD1;
    assign ex_rD2       = r_rD2;
    assign ex_ext       = r_ext;
    assign stall_cnt_o  = r_stall_cnt;
    assign flush_cnt_o  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Purpose  : Directed-vector scoreboard bench for id_ex_stage.
//  Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

    localparam int CNT_W = 8;
    localparam logic [3:0] c_ALU_ADD = 4'h0;

    localparam int K_LOAD  = 0;
    localparam int K_STALL = 1;
    localparam int K_FLUSH = 2;
    localparam int K_HOLD  = 3;
    localparam int K_RST   = 4;

    typedef struct packed {
        logic        have_inst;
        logic        read_rD1;
        logic        read_rD2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf_we;
        logic [1:0]  rf_wsel;
        logic [3:0]  alu_op;
        logic        alub_sel;
        logic        ram_we;
        logic [2:0]  branch;
        logic [31:0] pc;
        logic [31:0] rD1;
        logic [31:0] rD2;
        logic [31:0] ext;
    } word_t;

    typedef struct packed {
        logic             chk_stall;
        logic             exp_stall;
        word_t            w;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold_i = 1'b0;
    logic ex_flush_i = 1'b0;
    word_t id_word = '0;
    word_t act;

    logic             ex_have_inst, ex_read_rD1, ex_read_rD2;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic             ex_rf_we;
    logic [1:0]       ex_rf_wsel;
    logic [3:0]       ex_alu_op;
    logic             ex_alub_sel, ex_ram_we;
    logic [2:0]       ex_branch;
    logic [31:0]      ex_pc, ex_rD1, ex_rD2, ex_ext;
    logic             stall_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    entry_t q[$];
    word_t  last_w = '0;
    logic [CNT_W-1:0] exp_scnt = '0;
    logic [CNT_W-1:0] exp_fcnt = '0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(CNT_W), .WSEL_LOAD(2'b01)) dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .ex_flush_i(ex_flush_i),
        .id_have_inst(id_word.have_inst), .id_read_rD1(id_word.read_rD1), .id_read_rD2(id_word.read_rD2),
        .id_rs1(id_word.rs1), .id_rs2(id_word.rs2), .id_rd(id_word.rd),
        .id_rf_we(id_word.rf_we), .id_rf_wsel(id_word.rf_wsel), .id_alu_op(id_word.alu_op),
        .id_alub_sel(id_word.alub_sel), .id_ram_we(id_word.ram_we), .id_branch(id_word.branch),
        .id_pc(id_word.pc), .id_rD1(id_word.rD1), .id_rD2(id_word.rD2), .id_ext(id_word.ext),
        .ex_have_inst(ex_have_inst), .ex_read_rD1(ex_read_rD1), .ex_read_rD2(ex_read_rD2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rf_we(ex_rf_we), .ex_rf_wsel(ex_rf_wsel), .ex_alu_op(ex_alu_op),
        .ex_alub_sel(ex_alub_sel), .ex_ram_we(ex_ram_we), .ex_branch(ex_branch),
        .ex_pc(ex_pc), .ex_rD1(ex_rD1), .ex_rD2(ex_rD2), .ex_ext(ex_ext),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    assign act = {ex_have_inst, ex_read_rD1, ex_read_rD2, ex_rs1, ex_rs2, ex_rd, ex_rf_we,
                  ex_rf_wsel, ex_alu_op, ex_alub_sel, ex_ram_we, ex_branch,
                  ex_pc, ex_rD1, ex_rD2, ex_ext};

    function automatic word_t mk(input logic have, input logic r1, input logic r2,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic we, input logic [1:0] wsel, input logic bsel,
                                 input logic ramwe, input logic [2:0] br,
                                 input logic [31:0] pc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] ext);
        word_t w;
        w.have_inst = have; w.read_rD1 = r1; w.read_rD2 = r2;
        w.rs1 = rs1; w.rs2 = rs2; w.rd = rd;
        w.rf_we = we; w.rf_wsel = wsel; w.alu_op = c_ALU_ADD; w.alub_sel = bsel;
        w.ram_we = ramwe; w.branch = br;
        w.pc = pc; w.rD1 = a; w.rD2 = b; w.ext = ext;
        return w;
    endfunction

    // Drive one ID slot for one cycle and queue what EX must show after the edge.
    task automatic cyc(input word_t idw, input logic rst, input logic hold, input logic flush,
                       input int kind, input logic chk, input logic exp_stall);
        entry_t e;
        @(negedge clk);
        id_word = idw; rst_n = rst; hold_i = hold; ex_flush_i = flush;
        case (kind)
            K_LOAD:  last_w = idw;
            K_STALL: begin
                last_w = '0;
                if (exp_scnt != {CNT_W{1'b1}}) exp_scnt = exp_scnt + 1'b1;
            end
            K_FLUSH: begin
                last_w = '0;
                if (exp_fcnt != {CNT_W{1'b1}}) exp_fcnt = exp_fcnt + 1'b1;
            end
            K_RST: begin
                last_w = '0; exp_scnt = '0; exp_fcnt = '0;
            end
            default: ;
        endcase
        e.chk_stall = chk; e.exp_stall = exp_stall; e.w = last_w;
        e.scnt = exp_scnt; e.fcnt = exp_fcnt;
        q.push_back(e);
    endtask

    initial begin : monitor
        entry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q[0];
                if (e.chk_stall) begin
                    n_vec++;
                    if (stall_o !== e.exp_stall) begin
                        n_err++;
                        $display("FAIL stall_o @%0t: got %b want %b", $time, stall_o, e.exp_stall);
                    end
                end
                @(posedge clk);
                #1;
                e = q.pop_front();
                n_vec++;
                if (act !== e.w) begin
                    n_err++;
                    $display("FAIL ex_word @%0t: got %h want %h", $time, act, e.w);
                end
                n_vec++;
                if (stall_cnt_o !== e.scnt) begin
                    n_err++;
                    $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt_o, e.scnt);
                end
                n_vec++;
                if (flush_cnt_o !== e.fcnt) begin
                    n_err++;
                    $display("FAIL flush_cnt @%0t: got %0d want %0d", $time, flush_cnt_o, e.fcnt);
                end
            end
        end
    end

    initial begin : driver
        word_t add3, lw5, use5, lw7, use7b, addi_nr2, sw_i, jal_i, lw0, use0, noinst, lw9, use9;
        add3     = mk(1, 1, 1, 5'd1, 5'd2, 5'd3, 1, 2'b00, 0, 0, 3'b000, 32'h100, 32'h11, 32'h22, 32'h0);
        lw5      = mk(1, 1, 0, 5'd1, 5'd0, 5'd5, 1, 2'b01, 1, 0, 3'b000, 32'h104, 32'h1000, 32'h0, 32'h8);
        use5     = mk(1, 1, 1, 5'd5, 5'd2, 5'd6, 1, 2'b00, 0, 0, 3'b000, 32'h108, 32'hA, 32'hB, 32'h0);
        lw7      = mk(1, 1, 0, 5'd1, 5'd0, 5'd7, 1, 2'b01, 1, 0, 3'b000, 32'h10C, 32'h2000, 32'h0, 32'h4);
        use7b    = mk(1, 1, 1, 5'd4, 5'd7, 5'd8, 1, 2'b00, 0, 0, 3'b000, 32'h110, 32'h3, 32'h4, 32'h0);
        addi_nr2 = mk(1, 1, 0, 5'd2, 5'd7, 5'd9, 1, 2'b00, 1, 0, 3'b000, 32'h114, 32'h5, 32'h0, 32'h7);
        sw_i     = mk(1, 1, 1, 5'd1, 5'd2, 5'd0, 0, 2'b00, 1, 1, 3'b000, 32'h118, 32'h40, 32'h55, 32'hC);
        jal_i    = mk(1, 0, 0, 5'd0, 5'd0, 5'd1, 1, 2'b10, 0, 0, 3'b010, 32'h11C, 32'h0, 32'h0, 32'h20);
        lw0      = mk(1, 1, 0, 5'd1, 5'd0, 5'd0, 1, 2'b01, 1, 0, 3'b000, 32'h120, 32'h1000, 32'h0, 32'h0);
        use0     = mk(1, 1, 0, 5'd0, 5'd3, 5'd4, 1, 2'b00, 0, 0, 3'b000, 32'h124, 32'h0, 32'h9, 32'h0);
        noinst   = mk(0, 1, 0, 5'd5, 5'd0, 5'd6, 0, 2'b00, 0, 0, 3'b000, 32'h128, 32'h1, 32'h2, 32'h3);
        lw9      = mk(1, 1, 0, 5'd1, 5'd0, 5'd9, 1, 2'b01, 1, 0, 3'b000, 32'h200, 32'h80, 32'h0, 32'h0);
        use9     = mk(1, 0, 1, 5'd3, 5'd9, 5'd10, 1, 2'b00, 0, 0, 3'b000, 32'h204, 32'h1, 32'h2, 32'h0);

        // Reset with busy inputs: everything zero.
        cyc(add3, 0, 0, 1, K_RST, 0, 0);
        cyc(lw5,  0, 1, 0, K_RST, 0, 0);
        // Pass-through and plain loads.
        cyc(add3, 1, 0, 0, K_LOAD, 1, 0);
        cyc(sw_i, 1, 0, 0, K_LOAD, 1, 0);
        cyc(jal_i, 1, 0, 0, K_LOAD, 1, 0);
        // Load-use on rs1: one bubble, then the same instruction loads.
        cyc(lw5,  1, 0, 0, K_LOAD, 1, 0);
        cyc(use5, 1, 0, 0, K_STALL, 1, 1);
        cyc(use5, 1, 0, 0, K_LOAD, 1, 0);
        // Load-use on rs2, and a matching rs2 field that is not read.
        cyc(lw7,      1, 0, 0, K_LOAD, 1, 0);
        cyc(use7b,    1, 0, 0, K_STALL, 1, 1);
        cyc(use7b,    1, 0, 0, K_LOAD, 1, 0);
        cyc(lw7,      1, 0, 0, K_LOAD, 1, 0);
        cyc(addi_nr2, 1, 0, 0, K_LOAD, 1, 0);
        // Load to x0 never stalls.
        cyc(lw0,  1, 0, 0, K_LOAD, 1, 0);
        cyc(use0, 1, 0, 0, K_LOAD, 1, 0);
        // Empty ID slot behind a load passes through without stalling.
        cyc(lw5,    1, 0, 0, K_LOAD, 1, 0);
        cyc(noinst, 1, 0, 0, K_LOAD, 1, 0);
        // Flush overrides a simultaneous load-use.
        cyc(lw5,  1, 0, 0, K_LOAD, 1, 0);
        cyc(use5, 1, 0, 1, K_FLUSH, 1, 0);
        cyc(use5, 1, 0, 0, K_LOAD, 1, 0);
        // Hold freezes with flush and load-use pending; flush applies on release.
        cyc(lw5,  1, 0, 0, K_LOAD, 1, 0);
        cyc(use5, 1, 1, 1, K_HOLD, 1, 0);
        cyc(use5, 1, 1, 1, K_HOLD, 1, 0);
        cyc(use5, 1, 1, 1, K_HOLD, 1, 0);
        cyc(use5, 1, 0, 1, K_FLUSH, 1, 0);
        cyc(use5, 1, 0, 0, K_LOAD, 1, 0);
        // Reset during a stall: stall is visible that cycle, gone after.
        cyc(lw5,  1, 0, 0, K_LOAD, 1, 0);
        cyc(use5, 0, 0, 0, K_RST, 1, 1);
        cyc(use5, 1, 0, 0, K_LOAD, 1, 0);
        // Counter saturation.
        cyc(add3, 1, 0, 0, K_LOAD, 1, 0);
        for (int i = 0; i < 260; i++) begin
            cyc(lw9,  1, 0, 0, K_LOAD, 1, 0);
            cyc(use9, 1, 0, 0, K_STALL, 1, 1);
        end
        for (int i = 0; i < 260; i++) begin
            cyc(add3, 1, 0, 1, K_FLUSH, 1, 0);
        end
        cyc(add3, 0, 0, 0, K_RST, 1, 0);
        cyc(add3, 1, 0, 0, K_LOAD, 1, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
